// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the shared slow_memory arbiter.
// slave = arbiter view; master = the caches/memory environment driving it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) ();
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one slow_memory between I-cache and D-cache; one arbitration cycle, grant held until mem_ready.
// Strobes/ready are combinational from state; requesters are backpressured simply by holding their request.
module mem_arbiter #(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] i_wait_cnt,
    output logic [CNT_W-1:0] d_wait_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;
    typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    side_t             last_q, last_d;
    logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
    logic              req_i, req_d;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              rd_sel, wr_sel;

    assign req_i = bus.i_read;
    assign req_d = bus.d_read | bus.d_write;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // Tie: D wins in fixed-priority mode, otherwise the side that did not go last.
                if (req_i && req_d) begin
                    state_d = (PRIO_MODE != 0 || last_q == SIDE_I) ? GNT_D : GNT_I;
                end else if (req_i) begin
                    state_d = GNT_I;
                end else if (req_d) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                    last_d  = SIDE_I;
                end
            end
            GNT_D: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                    last_d  = SIDE_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;
        if (req_i && state_q != GNT_I && i_cnt_q != '1) begin
            i_cnt_d = i_cnt_q + CNT_ONE;
        end
        if (req_d && state_q != GNT_D && d_cnt_q != '1) begin
            d_cnt_d = d_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= SIDE_I;
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

    // Write wins when the D side raises both read and write.
    always_comb begin
        rd_sel    = 1'b0;
        wr_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        case (state_q)
            GNT_I: begin
                rd_sel   = 1'b1;
                addr_sel = bus.i_addr;
            end
            GNT_D: begin
                wr_sel    = bus.d_write;
                rd_sel    = bus.d_read & ~bus.d_write;
                addr_sel  = bus.d_addr;
                wdata_sel = bus.d_wdata;
            end
            default: ;
        endcase
    end

    assign bus.mem_read  = rd_sel;
    assign bus.mem_write = wr_sel;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;

    assign bus.i_ready = bus.mem_ready & (state_q == GNT_I);
    assign bus.d_ready = bus.mem_ready & (state_q == GNT_D);
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

    assign i_wait_cnt = i_cnt_q;
    assign d_wait_cnt = d_cnt_q;
endmodule
